// File: rtl/orientation_tracker_if.sv
// Sample/orientation bundle between the IMU sample path and the orientation tracker.
// Define ORIENT_TILT_MAG_EN to carry the tilt_mag result as well.
interface orientation_tracker_if #(
    parameter int DATA_W = 16
);
    logic                     sample_valid;
    logic signed [DATA_W-1:0] roll_raw;
    logic signed [DATA_W-1:0] pitch_raw;
    logic [3:0]               orientation;
    logic                     orient_chg;
    logic [1:0]               roll_dir;
    logic [1:0]               pitch_dir;
`ifdef ORIENT_TILT_MAG_EN
    logic [DATA_W-1:0]        tilt_mag;

    modport master (
        output sample_valid, roll_raw, pitch_raw,
        input  orientation, orient_chg, roll_dir, pitch_dir, tilt_mag
    );
    modport slave (
        input  sample_valid, roll_raw, pitch_raw,
        output orientation, orient_chg, roll_dir, pitch_dir, tilt_mag
    );
`else
    modport master (
        output sample_valid, roll_raw, pitch_raw,
        input  orientation, orient_chg, roll_dir, pitch_dir
    );
    modport slave (
        input  sample_valid, roll_raw, pitch_raw,
        output orientation, orient_chg, roll_dir, pitch_dir
    );
`endif
endinterface

// File: rtl/orientation_tracker.sv
// Roll/pitch orientation tracker: per-axis hysteresis FSMs feeding an N-sample stability filter.
// Optional ORIENT_TILT_MAG_EN adds a registered max(|roll|,|pitch|) output.
module orientation_tracker #(
    parameter int DATA_W     = 16,
    parameter int THRESH_HI  = 400,
    parameter int THRESH_LO  = 300,
    parameter int STABLE_CNT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    orientation_tracker_if.slave  bus
);
    typedef enum logic [1:0] {
        AX_NEU = 2'b00,
        AX_POS = 2'b01,
        AX_NEG = 2'b11
    } axis_e;

    localparam int CNT_W = $clog2(STABLE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);
    localparam logic signed [DATA_W:0] HI_POS = (DATA_W + 1)'(THRESH_HI);
    localparam logic signed [DATA_W:0] HI_NEG = -HI_POS;
    localparam logic signed [DATA_W:0] LO_POS = (DATA_W + 1)'(THRESH_LO);
    localparam logic signed [DATA_W:0] LO_NEG = -LO_POS;

    // Index 0 is roll, index 1 is pitch; encodings double as the signed dir outputs.
    logic [1:0] dir_q_vec [2];
    logic [1:0] dir_d_vec [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            logic signed [DATA_W-1:0] raw;
            logic signed [DATA_W:0]   x_ext;
            axis_e                    state_q;
            axis_e                    state_d;

            assign raw   = (gi == 0) ? bus.roll_raw : bus.pitch_raw;
            assign x_ext = $signed({raw[DATA_W-1], raw});

            always_comb begin
                state_d = state_q;
                if (bus.sample_valid) begin
                    case (state_q)
                        AX_NEU: begin
                            if (x_ext > HI_POS)      state_d = AX_POS;
                            else if (x_ext < HI_NEG) state_d = AX_NEG;
                        end
                        AX_POS: begin
                            if (x_ext < HI_NEG)       state_d = AX_NEG;
                            else if (x_ext <= LO_POS) state_d = AX_NEU;
                        end
                        AX_NEG: begin
                            if (x_ext > HI_POS)       state_d = AX_POS;
                            else if (x_ext >= LO_NEG) state_d = AX_NEU;
                        end
                        default: state_d = AX_NEU;
                    endcase
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) state_q <= AX_NEU;
                else        state_q <= state_d;
            end

            assign dir_q_vec[gi] = state_q;
            assign dir_d_vec[gi] = state_d;
        end
    endgenerate

    function automatic logic [3:0] map_code(input logic [1:0] pdir, input logic [1:0] rdir);
        case ({pdir, rdir})
            {AX_POS, AX_NEU}: map_code = 4'd1;
            {AX_POS, AX_POS}: map_code = 4'd2;
            {AX_NEU, AX_POS}: map_code = 4'd3;
            {AX_NEG, AX_POS}: map_code = 4'd4;
            {AX_NEG, AX_NEU}: map_code = 4'd5;
            {AX_NEG, AX_NEG}: map_code = 4'd6;
            {AX_NEU, AX_NEG}: map_code = 4'd7;
            {AX_POS, AX_NEG}: map_code = 4'd8;
            default:          map_code = 4'd0;
        endcase
    endfunction

    logic [3:0]       cand;
    logic [3:0]       orient_q, orient_d;
    logic [3:0]       pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_new;
    logic             chg_q, chg_d;

    // Candidate uses next-state axes so the filter sees this sample's classification.
    assign cand = map_code(dir_d_vec[1], dir_d_vec[0]);

    always_comb begin
        orient_d = orient_q;
        pend_d   = pend_q;
        cnt_d    = cnt_q;
        cnt_new  = cnt_q;
        chg_d    = 1'b0;
        if (bus.sample_valid) begin
            if (cand == orient_q) begin
                cnt_d = '0;
            end else begin
                if (cand == pend_q && cnt_q != '0) begin
                    cnt_new = cnt_q + CNT_W'(1);
                end else begin
                    pend_d  = cand;
                    cnt_new = CNT_W'(1);
                end
                if (cnt_new == CNT_MAX) begin
                    orient_d = cand;
                    chg_d    = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_new;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            orient_q <= '0;
            pend_q   <= '0;
            cnt_q    <= '0;
            chg_q    <= 1'b0;
        end else begin
            orient_q <= orient_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            chg_q    <= chg_d;
        end
    end

    assign bus.orientation = orient_q;
    assign bus.orient_chg  = chg_q;
    assign bus.roll_dir    = dir_q_vec[0];
    assign bus.pitch_dir   = dir_q_vec[1];

`ifdef ORIENT_TILT_MAG_EN
    // The most-negative sample has no positive twin, so it saturates.
    function automatic logic [DATA_W-1:0] abs_sat(input logic signed [DATA_W-1:0] x);
        if (x == {1'b1, {(DATA_W-1){1'b0}}}) abs_sat = {1'b0, {(DATA_W-1){1'b1}}};
        else if (x[DATA_W-1])                 abs_sat = -x;
        else                                  abs_sat = x;
    endfunction

    logic [DATA_W-1:0] roll_abs, pitch_abs;
    logic [DATA_W-1:0] tilt_q, tilt_d;

    assign roll_abs  = abs_sat(bus.roll_raw);
    assign pitch_abs = abs_sat(bus.pitch_raw);

    always_comb begin
        tilt_d = tilt_q;
        if (bus.sample_valid) tilt_d = (roll_abs > pitch_abs) ? roll_abs : pitch_abs;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tilt_q <= '0;
        else        tilt_q <= tilt_d;
    end

    assign bus.tilt_mag = tilt_q;
`endif
endmodule

// File: tb/tb_orientation_tracker.sv
// Self-checking bench for orientation_tracker: directed scenarios plus randomized runs
// against an integer reference model of the axis and stability rules.
module tb_orientation_tracker;
    localparam int DATA_W = 16;
    localparam int HI     = 400;
    localparam int LO     = 300;
    localparam int SC     = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    orientation_tracker_if #(.DATA_W(DATA_W)) bus ();

    orientation_tracker #(
        .DATA_W(DATA_W), .THRESH_HI(HI), .THRESH_LO(LO), .STABLE_CNT(SC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: axis states as -1/0/+1, codes from a (pitch,roll) table.
    int m_roll, m_pitch, m_orient, m_pend, m_cnt, m_chg, m_tilt;
    int code_tbl [3][3] = '{'{6, 5, 4}, '{7, 0, 3}, '{8, 1, 2}};

    function automatic int axis_next(input int s, input int x);
        if (s == 0)      return (x > HI) ? 1 : ((x < -HI) ? -1 : 0);
        else if (s == 1) return (x < -HI) ? -1 : ((x <= LO) ? 0 : 1);
        else             return (x > HI) ? 1 : ((x >= -LO) ? 0 : -1);
    endfunction

    function automatic int abs_sat(input int v);
        if (v == -(1 << (DATA_W - 1))) return (1 << (DATA_W - 1)) - 1;
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        m_roll = 0; m_pitch = 0; m_orient = 0; m_pend = 0; m_cnt = 0; m_chg = 0; m_tilt = 0;
    endtask

    task automatic model_step(input logic v, input int r, input int p);
        int cand;
        m_chg = 0;
        if (v) begin
            m_roll  = axis_next(m_roll, r);
            m_pitch = axis_next(m_pitch, p);
            m_tilt  = (abs_sat(r) > abs_sat(p)) ? abs_sat(r) : abs_sat(p);
            cand    = code_tbl[m_pitch + 1][m_roll + 1];
            if (cand == m_orient) begin
                m_cnt = 0;
            end else begin
                if (cand == m_pend && m_cnt != 0) m_cnt++;
                else begin m_pend = cand; m_cnt = 1; end
                if (m_cnt == SC) begin m_orient = cand; m_chg = 1; m_cnt = 0; end
            end
        end
    endtask

    function automatic logic [8:0] exp_vec();
        return {4'(m_orient), 1'(m_chg), 2'(m_roll), 2'(m_pitch)};
    endfunction

    function automatic logic [8:0] act_vec();
        return {bus.orientation, bus.orient_chg, bus.roll_dir, bus.pitch_dir};
    endfunction

    task automatic sample(input logic v, input int r, input int p);
        @(negedge clk);
        bus.sample_valid = v;
        bus.roll_raw     = DATA_W'(r);
        bus.pitch_raw    = DATA_W'(p);
        @(posedge clk);
        #1;
        model_step(v, r, p);
        bus.sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.sample_valid = 1'b0; bus.roll_raw = '0; bus.pitch_raw = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (act_vec() !== 9'd0) begin
            errors++; $display("FAIL reset_state got=%h want=%h", act_vec(), 9'd0);
        end
`ifdef ORIENT_TILT_MAG_EN
        checks++;
        if (bus.tilt_mag !== '0) begin
            errors++; $display("FAIL reset_tilt got=%0d want=0", bus.tilt_mag);
        end
`endif
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sample(1'b1, 0, 0);
            checks++;
            if (act_vec() !== 9'd0) begin
                errors++; $display("FAIL zero_sample%0d got=%h want=%h", i, act_vec(), 9'd0);
            end
        end
        $display("test_reset done errors=%0d", errors);
    endtask

    task automatic test_right_commit();
        for (int i = 1; i <= 4; i++) begin
            sample(1'b1, 500, 0);
            checks++;
            if (bus.roll_dir !== 2'b01) begin
                errors++; $display("FAIL right_roll_dir s%0d got=%b want=01", i, bus.roll_dir);
            end
            checks++;
            if (bus.orient_chg !== (i == 4)) begin
                errors++; $display("FAIL right_chg s%0d got=%b want=%b", i, bus.orient_chg, (i == 4));
            end
            checks++;
            if (bus.orientation !== ((i == 4) ? 4'd3 : 4'd0)) begin
                errors++; $display("FAIL right_orient s%0d got=%0d want=%0d", i, bus.orientation, (i == 4) ? 3 : 0);
            end
        end
        $display("test_right_commit done errors=%0d", errors);
    endtask

    task automatic test_hysteresis();
        for (int i = 0; i < 4; i++) begin
            sample(1'b1, 350, 0);
            checks++;
            if (bus.roll_dir !== 2'b01 || bus.orientation !== 4'd3 || bus.orient_chg !== 1'b0) begin
                errors++; $display("FAIL hyst_hold s%0d got dir=%b orient=%0d chg=%b want dir=01 orient=3 chg=0",
                                   i, bus.roll_dir, bus.orientation, bus.orient_chg);
            end
        end
        for (int i = 1; i <= 4; i++) begin
            sample(1'b1, 300, 0);
            checks++;
            if (bus.roll_dir !== 2'b00) begin
                errors++; $display("FAIL hyst_release_dir s%0d got=%b want=00", i, bus.roll_dir);
            end
            checks++;
            if (bus.orientation !== ((i == 4) ? 4'd0 : 4'd3) || bus.orient_chg !== (i == 4)) begin
                errors++; $display("FAIL hyst_release_orient s%0d got=%0d/%b want=%0d/%b",
                                   i, bus.orientation, bus.orient_chg, (i == 4) ? 0 : 3, (i == 4));
            end
        end
        $display("test_hysteresis done errors=%0d", errors);
    endtask

    task automatic test_chatter();
        for (int i = 0; i < 8; i++) begin
            sample(1'b1, 0, (i % 2 == 0) ? 500 : 0);
            checks++;
            if (bus.orientation !== 4'd0 || bus.orient_chg !== 1'b0 || act_vec() !== exp_vec()) begin
                errors++; $display("FAIL chatter s%0d got=%h want=%h", i, act_vec(), exp_vec());
            end
        end
        $display("test_chatter done errors=%0d", errors);
    endtask

    task automatic test_direct_jump();
        for (int i = 1; i <= 4; i++) begin
            sample(1'b1, -32768, -401);
            checks++;
            if (bus.roll_dir !== 2'b11 || bus.pitch_dir !== 2'b11) begin
                errors++; $display("FAIL jump_dirs s%0d got=%b/%b want=11/11", i, bus.roll_dir, bus.pitch_dir);
            end
            checks++;
            if (bus.orientation !== ((i == 4) ? 4'd6 : 4'd0) || bus.orient_chg !== (i == 4)) begin
                errors++; $display("FAIL jump_orient s%0d got=%0d/%b want=%0d/%b",
                                   i, bus.orientation, bus.orient_chg, (i == 4) ? 6 : 0, (i == 4));
            end
`ifdef ORIENT_TILT_MAG_EN
            checks++;
            if (bus.tilt_mag !== 16'd32767) begin
                errors++; $display("FAIL jump_tilt s%0d got=%0d want=32767", i, bus.tilt_mag);
            end
`endif
        end
        sample(1'b1, 500, -401);
        checks++;
        if (bus.roll_dir !== 2'b01 || bus.orientation !== 4'd6) begin
            errors++; $display("FAIL neg_to_pos got dir=%b orient=%0d want dir=01 orient=6", bus.roll_dir, bus.orientation);
        end
        $display("test_direct_jump done errors=%0d", errors);
    endtask

    task automatic test_gaps();
        int chg_seen = 0;
        for (int i = 0; i < 3; i++) begin
            for (int g = 0; g < 3; g++) begin
                sample(1'b0, -20000, 20000);
                checks++;
                if (act_vec() !== exp_vec()) begin
                    errors++; $display("FAIL gap_hold i%0d g%0d got=%h want=%h", i, g, act_vec(), exp_vec());
                end
                chg_seen += int'(bus.orient_chg);
            end
            sample(1'b1, 500, -500);
            chg_seen += int'(bus.orient_chg);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++; $display("FAIL gap_valid i%0d got=%h want=%h", i, act_vec(), exp_vec());
            end
        end
        checks++;
        if (bus.orientation !== 4'd4 || chg_seen != 1) begin
            errors++; $display("FAIL gap_commit got orient=%0d pulses=%0d want orient=4 pulses=1", bus.orientation, chg_seen);
        end
        $display("test_gaps done errors=%0d", errors);
    endtask

    task automatic test_reset_mid();
        @(negedge clk) rst_n = 1'b0;
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 3; i++) sample(1'b1, 500, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (act_vec() !== 9'd0) begin
            errors++; $display("FAIL async_reset got=%h want=%h", act_vec(), 9'd0);
        end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            sample(1'b1, 500, 0);
            checks++;
            if (bus.orientation !== ((i == 4) ? 4'd3 : 4'd0) || bus.orient_chg !== (i == 4)) begin
                errors++; $display("FAIL reset_mid s%0d got=%0d/%b want=%0d/%b",
                                   i, bus.orientation, bus.orient_chg, (i == 4) ? 3 : 0, (i == 4));
            end
        end
        $display("test_reset_mid done errors=%0d", errors);
    endtask

    function automatic int pick();
        case ($urandom_range(0, 11))
            0:  return 0;
            1:  return 300;
            2:  return -300;
            3:  return 301;
            4:  return -301;
            5:  return 400;
            6:  return -400;
            7:  return 401;
            8:  return -401;
            9:  return -32768;
            10: return 32767;
            default: return int'($urandom_range(0, 2000)) - 1000;
        endcase
    endfunction

    task automatic test_random();
        int r, p, n;
        logic v;
        for (int run = 0; run < 80; run++) begin
            r = pick();
            p = pick();
            n = int'($urandom_range(1, 6));
            for (int k = 0; k < n; k++) begin
                v = ($urandom_range(0, 3) != 0);
                sample(v, r, p);
                checks++;
                if (act_vec() !== exp_vec()) begin
                    errors++; $display("FAIL random run%0d k%0d v=%b r=%0d p=%0d got=%h want=%h",
                                       run, k, v, r, p, act_vec(), exp_vec());
                end
`ifdef ORIENT_TILT_MAG_EN
                checks++;
                if (bus.tilt_mag !== DATA_W'(m_tilt)) begin
                    errors++; $display("FAIL random_tilt run%0d got=%0d want=%0d", run, bus.tilt_mag, m_tilt);
                end
`endif
            end
        end
        $display("test_random done errors=%0d", errors);
    endtask

    initial begin
        test_reset();
        test_right_commit();
        test_hysteresis();
        test_chatter();
        test_direct_jump();
        test_gaps();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
